// File: rtl/timer_bridge.sv
// timer_bridge: routes MEM-stage CPU accesses to data memory or to one of two
// memory-mapped timers, and raises per-timer interrupts.
// Each timer has CTRL (EN, MODE, IM), PRESET and a read-only COUNT register.
module timer_bridge #(
    parameter logic [31:0] DM_TOP  = 32'h0000_2FFF,
    parameter logic [31:0] T0_BASE = 32'h0000_7F00,
    parameter logic [31:0] T1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    input  logic        cpu_rd,
    output logic [31:0] cpu_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  irq,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timer_state_t;

    localparam logic [1:0] OFS_CTRL   = 2'b00;
    localparam logic [1:0] OFS_PRESET = 2'b01;
    localparam logic [1:0] OFS_COUNT  = 2'b10;

    logic [3:0]   ctrl     [2];
    logic [31:0]  preset   [2];
    logic [31:0]  count    [2];
    timer_state_t state    [2];
    logic [1:0]   irq_flag;

    logic         dm_hit;
    logic [1:0]   t_hit;
    logic         is_store;
    logic         full_word;
    logic [1:0]   wr_ctrl;
    logic [1:0]   wr_preset;

    // Address decode; data memory wins if a timer block ever overlaps it.
    always_comb begin
        dm_hit    = (cpu_addr <= DM_TOP);
        t_hit[0]  = !dm_hit && (cpu_addr[31:4] == T0_BASE[31:4]) && (cpu_addr[3:2] != 2'b11);
        t_hit[1]  = !dm_hit && (cpu_addr[31:4] == T1_BASE[31:4]) && (cpu_addr[3:2] != 2'b11);
        is_store  = (cpu_byteen != 4'b0000);
        full_word = (cpu_byteen == 4'b1111);
        for (int n = 0; n < 2; n++) begin
            wr_ctrl[n]   = t_hit[n] && full_word && (cpu_addr[3:2] == OFS_CTRL);
            wr_preset[n] = t_hit[n] && full_word && (cpu_addr[3:2] == OFS_PRESET);
        end
    end

    // Data memory sees address and data unconditionally; only its enables are gated.
    always_comb begin
        dm_addr   = cpu_addr;
        dm_wdata  = cpu_wdata;
        dm_byteen = dm_hit ? cpu_byteen : 4'b0000;
    end

    // Load data mux: memory, timer register, or zero for unmapped addresses.
    always_comb begin
        cpu_rdata = 32'h0;
        if (dm_hit) begin
            cpu_rdata = dm_rdata;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (t_hit[n]) begin
                    case (cpu_addr[3:2])
                        OFS_CTRL:   cpu_rdata = {28'h0, ctrl[n]};
                        OFS_PRESET: cpu_rdata = preset[n];
                        OFS_COUNT:  cpu_rdata = count[n];
                        default:    cpu_rdata = 32'h0;
                    endcase
                end
            end
        end
    end

    // Illegal access: unmapped access, partial timer store, or store to read-only COUNT.
    always_comb begin
        addr_err = ((cpu_rd || is_store) && !(dm_hit || t_hit[0] || t_hit[1]))
                || ((t_hit[0] || t_hit[1]) && is_store && !full_word)
                || ((t_hit[0] || t_hit[1]) && is_store && (cpu_addr[3:2] == OFS_COUNT));
    end

    // Interrupt is the registered flag masked by the registered IM bit.
    always_comb begin
        irq = irq_flag & {ctrl[1][3], ctrl[0][3]};
    end

    // Timer registers and FSMs; a CTRL write overrides whatever the FSM would do this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                ctrl[n]     <= 4'h0;
                preset[n]   <= 32'h0;
                count[n]    <= 32'h0;
                state[n]    <= IDLE;
                irq_flag[n] <= 1'b0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (wr_preset[n]) begin
                    preset[n] <= cpu_wdata;
                end
                if (wr_ctrl[n]) begin
                    ctrl[n]     <= cpu_wdata[3:0];
                    irq_flag[n] <= 1'b0;
                    state[n]    <= IDLE;
                end else begin
                    case (state[n])
                        IDLE: begin
                            if (ctrl[n][0]) begin
                                state[n] <= LOAD;
                            end
                        end
                        LOAD: begin
                            count[n] <= preset[n];
                            state[n] <= CNT;
                        end
                        CNT: begin
                            if (!ctrl[n][0]) begin
                                state[n] <= IDLE;
                            end else if (count[n] == 32'h0) begin
                                state[n]    <= INT;
                                irq_flag[n] <= 1'b1;
                            end else begin
                                count[n] <= count[n] - 32'h1;
                            end
                        end
                        INT: begin
                            if (ctrl[n][2:1] == 2'b01) begin
                                state[n]    <= LOAD;
                                irq_flag[n] <= 1'b0;
                            end else begin
                                ctrl[n][0] <= 1'b0;
                                state[n]   <= IDLE;
                            end
                        end
                        default: state[n] <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_bridge.sv
// tb_timer_bridge: directed checks of the timer bridge decode, timers and reset.
module tb_timer_bridge;

    localparam logic [31:0] T0_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] T0_PRESET = 32'h0000_7F04;
    localparam logic [31:0] T0_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] T1_CTRL   = 32'h0000_7F10;
    localparam logic [31:0] T1_PRESET = 32'h0000_7F14;
    localparam logic [31:0] T1_COUNT  = 32'h0000_7F18;
    localparam logic [31:0] DM_DATA   = 32'hCAFE_F00D;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_rd;
    logic [31:0] cpu_rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_rdata;
    logic [1:0]  irq;
    logic        addr_err;

    int assertCount = 0;
    int failCount   = 0;

    timer_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_byteen (cpu_byteen),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_byteen  (dm_byteen),
        .dm_rdata   (dm_rdata),
        .irq        (irq),
        .addr_err   (addr_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] byteen, input logic rd);
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        cpu_byteen = byteen;
        cpu_rd     = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(addr, wdata, 4'b1111, 1'b0);
        tick();
        applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr,
                             input logic [31:0] expected);
        applyStimulus(addr, 32'h0, 4'b0000, 1'b1);
        #1;
        checkOutput(tag, cpu_rdata, expected);
        applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0);
    endtask

    // Directed scenario sequence.
    initial begin
        reset    = 1'b0;
        dm_rdata = DM_DATA;
        applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0);
        #2;
        $display("[TB] reset state");
        checkOutput("rst_irq", {30'h0, irq}, 32'h0);
        readCheck("rst_t0_ctrl", T0_CTRL, 32'h0);
        readCheck("rst_t0_count", T0_COUNT, 32'h0);
        readCheck("rst_t1_preset", T1_PRESET, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        $display("[TB] data memory pass-through");
        applyStimulus(32'h0000_0100, 32'h1234_5678, 4'b0011, 1'b0);
        #1;
        checkOutput("dm_byteen", {28'h0, dm_byteen}, 32'h3);
        checkOutput("dm_addr", dm_addr, 32'h0000_0100);
        checkOutput("dm_wdata", dm_wdata, 32'h1234_5678);
        checkOutput("dm_store_err", {31'h0, addr_err}, 32'h0);
        checkOutput("dm_store_irq", {30'h0, irq}, 32'h0);
        tick();
        applyStimulus(32'h0000_0100, 32'h0, 4'b0000, 1'b1);
        #1;
        checkOutput("dm_load_rdata", cpu_rdata, DM_DATA);
        checkOutput("dm_load_err", {31'h0, addr_err}, 32'h0);
        applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0);
        tick();

        $display("[TB] illegal accesses");
        applyStimulus(32'h0000_5000, 32'h0, 4'b0000, 1'b1);
        #1;
        checkOutput("unmapped_rdata", cpu_rdata, 32'h0);
        checkOutput("unmapped_err", {31'h0, addr_err}, 32'h1);
        applyStimulus(32'h0000_7F0C, 32'h0, 4'b0000, 1'b1);
        #1;
        checkOutput("hole_err", {31'h0, addr_err}, 32'h1);
        applyStimulus(T0_CTRL, 32'h0000_000F, 4'b0001, 1'b0);
        #1;
        checkOutput("partial_err", {31'h0, addr_err}, 32'h1);
        checkOutput("partial_dm_byteen", {28'h0, dm_byteen}, 32'h0);
        tick();
        applyStimulus(T0_COUNT, 32'h0000_00AA, 4'b1111, 1'b0);
        #1;
        checkOutput("count_store_err", {31'h0, addr_err}, 32'h1);
        tick();
        applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0);
        readCheck("partial_ctrl_kept", T0_CTRL, 32'h0);
        readCheck("count_store_kept", T0_COUNT, 32'h0);
        tick();

        $display("[TB] timer1 auto-reload");
        busWrite(T1_PRESET, 32'h2);
        busWrite(T1_CTRL, 32'hB);
        for (int i = 1; i <= 15; i++) begin
            tick();
            checkOutput($sformatf("reload_irq_c%0d", i), {30'h0, irq},
                        ((i % 5) == 0) ? 32'h2 : 32'h0);
            if ((i % 5) == 2) begin
                readCheck($sformatf("reload_count_c%0d", i), T1_COUNT, 32'h2);
            end
        end
        busWrite(T1_CTRL, 32'h0);
        checkOutput("reload_stop_irq", {30'h0, irq}, 32'h0);

        $display("[TB] timer0 one-shot");
        busWrite(T0_PRESET, 32'h3);
        busWrite(T0_CTRL, 32'h9);
        readCheck("oneshot_ctrl_written", T0_CTRL, 32'h9);
        tick();
        tick();
        readCheck("oneshot_count_k2", T0_COUNT, 32'h3);
        tick();
        tick();
        tick();
        readCheck("oneshot_count_k5", T0_COUNT, 32'h0);
        checkOutput("oneshot_irq_k5", {30'h0, irq}, 32'h0);
        tick();
        checkOutput("oneshot_irq_k6", {30'h0, irq}, 32'h1);
        tick();
        readCheck("oneshot_ctrl_k7", T0_CTRL, 32'h8);
        checkOutput("oneshot_irq_k7", {30'h0, irq}, 32'h1);
        tick();
        tick();
        tick();
        checkOutput("oneshot_irq_held", {30'h0, irq}, 32'h1);
        readCheck("oneshot_count_held", T0_COUNT, 32'h0);

        $display("[TB] ctrl write vs leaving INT");
        busWrite(T0_CTRL, 32'h9);
        checkOutput("conflict_irq_cleared", {30'h0, irq}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        checkOutput("conflict_irq_int", {30'h0, irq}, 32'h1);
        busWrite(T0_CTRL, 32'h9);
        readCheck("conflict_ctrl_en", T0_CTRL, 32'h9);
        checkOutput("conflict_irq", {30'h0, irq}, 32'h0);
        tick();
        readCheck("conflict_count_load", T0_COUNT, 32'h0);
        tick();
        readCheck("conflict_recount", T0_COUNT, 32'h3);

        $display("[TB] reset mid-count");
        busWrite(T0_CTRL, 32'h0);
        busWrite(T0_PRESET, 32'h7);
        busWrite(T1_PRESET, 32'h5);
        busWrite(T0_CTRL, 32'h9);
        tick();
        tick();
        tick();
        tick();
        readCheck("midrst_count_before", T0_COUNT, 32'h5);
        reset = 1'b0;
        #1;
        readCheck("midrst_count", T0_COUNT, 32'h0);
        readCheck("midrst_ctrl", T0_CTRL, 32'h0);
        readCheck("midrst_preset", T0_PRESET, 32'h0);
        readCheck("midrst_t1_preset", T1_PRESET, 32'h0);
        checkOutput("midrst_irq", {30'h0, irq}, 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        readCheck("post_rst_count", T0_COUNT, 32'h0);
        readCheck("post_rst_ctrl", T0_CTRL, 32'h0);
        checkOutput("post_rst_irq", {30'h0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/timer_bridge.md
TIMER_BRIDGE -- requirements
Module: timer_bridge

Interface
REQ-001 SHALL have parameter DM_TOP, default 32'h0000_2FFF, highest byte address mapped to data memory.
REQ-002 SHALL have parameter T0_BASE, default 32'h0000_7F00, Timer0 register block base.
REQ-003 SHALL have parameter T1_BASE, default 32'h0000_7F10, Timer1 register block base.
REQ-004 SHALL have ports, clock and reset first; one clock, reset asynchronous active-low:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset (0 = reset).
- cpu_addr  in  32  MEM-stage byte address from datapath.
- cpu_wdata  in  32  MEM-stage store data.
- cpu_byteen  in  4  MEM-stage byte enables; nonzero = store.
- cpu_rd  in  1  MEM-stage load active.
- cpu_rdata  out  32  load data back to datapath.
- dm_addr  out  32  data memory address.
- dm_wdata  out  32  data memory store data.
- dm_byteen  out  4  data memory byte enables.
- dm_rdata  in  32  data memory read data.
- irq  out  2  interrupt, bit0 Timer0, bit1 Timer1.
- addr_err  out  1  illegal access flag.

Function
REQ-005 SHALL decode combinationally: DM hit = cpu_addr <= DM_TOP; Tn hit = cpu_addr[31:4]==Tn_BASE[31:4] and cpu_addr[3:2]!=2'b11.
REQ-006 SHALL drive dm_addr=cpu_addr and dm_wdata=cpu_wdata always; dm_byteen=cpu_byteen on DM hit, else 4'b0000.
REQ-007 SHALL drive cpu_rdata: DM hit -> dm_rdata; Tn hit -> selected Tn register; otherwise 32'h0.
REQ-008 SHALL provide per timer: CTRL (offset 0: bit0 EN, bits2:1 MODE, bit3 IM, bits31:4 read 0), PRESET (offset 4), COUNT (offset 8, read-only).
REQ-009 SHALL write CTRL/PRESET on the clk rising edge only when Tn hit and cpu_byteen==4'b1111; COUNT writes and partial writes to timers are ignored.
REQ-010 SHALL assert addr_err combinationally when (cpu_rd or cpu_byteen!=0) with no hit, or timer store with cpu_byteen not 4'b1111, or store to COUNT.
REQ-011 SHALL implement per-timer FSM IDLE, LOAD, CNT, INT:
- IDLE: EN=1 -> LOAD.
- LOAD: COUNT<=PRESET -> CNT.
- CNT: EN=0 -> IDLE, COUNT held; COUNT==0 -> INT, irq_flag<=1; else COUNT<=COUNT-1.
- INT, MODE 0/2/3: EN<=0 -> IDLE; irq_flag held.
- INT, MODE 1: -> LOAD; irq_flag<=0, giving a one-cycle pulse.
REQ-012 SHALL drive irq[n] = irq_flag[n] & IM[n], registered-flag based, glitch-free.
REQ-013 SHALL, on CTRL write, clear irq_flag and force state IDLE in the same edge; CPU write has priority over any same-edge FSM update of EN.
REQ-014 SHALL not disturb state or COUNT on PRESET write; new PRESET is used at the next LOAD.
REQ-015 SHALL, with PRESET=0, go LOAD -> CNT -> INT, raising irq two edges after LOAD.
REQ-016 SHALL keep COUNT 32-bit unsigned, with no decrement below 0.
REQ-017 SHALL update Timer0 and Timer1 independently.

Reset
REQ-018 SHALL, while reset=0, asynchronously clear CTRL, PRESET, COUNT, irq_flag to 0 and state to IDLE; irq=2'b00.
REQ-019 SHALL abort counting on reset asserted mid-count with no residual irq, resuming only after CTRL is rewritten with EN=1.

Verification
REQ-020 SHALL cover DM pass-through: store 0x12345678, byteen 4'b0011, addr 0x0000_0100 -> dm_byteen=4'b0011, irq=0, addr_err=0; load returns dm_rdata.
REQ-021 SHALL cover one-shot: PRESET=3 at T0_BASE+4, then CTRL=0x9 at edge k -> COUNT=3 after k+2, 0 after k+5, irq[0]=1 after k+6; CTRL reads 0x8 after k+7; irq stays 1 until a CTRL write clears it.
REQ-022 SHALL cover auto-reload: Timer1 PRESET=2, CTRL=0xB -> irq[1] high exactly one cycle every 5 cycles, COUNT reloads to 2.
REQ-023 SHALL cover errors: load from 0x0000_5000 -> cpu_rdata=0, addr_err=1; store byteen 4'b0001 to T0_BASE -> CTRL unchanged, addr_err=1; store to T0_BASE+8 -> COUNT unchanged, addr_err=1.
REQ-024 SHALL cover conflict: CTRL write with EN=1 on the same edge Timer0 would leave INT -> EN=1, irq_flag=0, state IDLE, then recount.
REQ-025 SHALL cover reset mid-count: reset=0 while COUNT=5 -> all registers 0 immediately, irq=0, no counting after release.
